neopixel_strand_ctrl_p: RTL and testbench

Parametrised NeoPixel (WS2812-class) strand driver. It holds per-pixel colour in a double-buffered frame store and serialises one frame onto a single-wire output. Each bit uses programmable high/low cycle counts, and the frame ends with a programmable latch gap. It supports 3-channel (GRB) or 4-channel (GRBW) pixels, an optional auto-refresh mode, and loads that remain legal while a frame is in flight. It sits between the host control logic and the strand pin.

---
 rtl/neopixel_pkg.sv | 40 ++++
 rtl/neopixel_strand_ctrl_p_if.sv | 27 ++
 rtl/neopixel_bit_encoder.sv | 68 ++++++
 rtl/neopixel_strand_ctrl_p.sv | 154 +++++++++++++++
 tb/tb_neopixel_strand_ctrl_p.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/neopixel_pkg.sv
// Shared definitions for the NeoPixel strand controller.
// Holds FSM state codes, host colour-index codes, wire-order channel slots
// and small constant helpers used when sizing counters.
package neopixel_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SEND_HI = 2'd1;
  localparam state_t ST_SEND_LO = 2'd2;
  localparam state_t ST_LATCH   = 2'd3;

  // Host-side colour_index encoding
  localparam logic [1:0] COLOR_RED   = 2'd0;
  localparam logic [1:0] COLOR_BLUE  = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_WHITE = 2'd3;

  // Byte slot of each channel within a pixel, in the order it goes on the wire
  localparam logic [1:0] WIRE_G = 2'd0;
  localparam logic [1:0] WIRE_R = 2'd1;
  localparam logic [1:0] WIRE_B = 2'd2;
  localparam logic [1:0] WIRE_W = 2'd3;

  function automatic logic [1:0] color_to_wire(input logic [1:0] ci);
    logic [1:0] slot;
    case (ci)
      COLOR_RED:   slot = WIRE_R;
      COLOR_BLUE:  slot = WIRE_B;
      COLOR_GREEN: slot = WIRE_G;
      default:     slot = WIRE_W;
    endcase
    return slot;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neopixel_strand_ctrl_p_if.sv
// Host-side bus of the NeoPixel strand controller.
// master: host logic (drives colour loads, send requests, auto-refresh mode).
// slave:  controller (returns ready flags, busy and the load-reject pulse).
interface neopixel_strand_ctrl_p_if #(
  parameter int PIX_W = 3
);
  logic [7:0]       color_level;
  logic [1:0]       color_index;
  logic [PIX_W-1:0] pixel_index;
  logic             load_color;
  logic             send_it;
  logic             auto_refresh;
  logic             ready_to_load;
  logic             ready_to_send;
  logic             busy;
  logic             load_error;

  modport master (
    output color_level, color_index, pixel_index, load_color, send_it, auto_refresh,
    input  ready_to_load, ready_to_send, busy, load_error
  );

  modport slave (
    input  color_level, color_index, pixel_index, load_color, send_it, auto_refresh,
    output ready_to_load, ready_to_send, busy, load_error
  );
endinterface

// File: rtl/neopixel_bit_encoder.sv
// Single-bit waveform generator: high for T1H/T0H cycles, then low for T1L/T0L.
// Ports: clock/reset; start_i (begin a bit next cycle), bit_i (held for the whole bit);
// line_o (wire level), hi_done_o (last high cycle), done_o (last low cycle).
module neopixel_bit_encoder #(
  parameter int T1H   = 35,
  parameter int T1L   = 30,
  parameter int T0H   = 18,
  parameter int T0L   = 40,
  parameter int CNT_W = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  input  logic bit_i,
  output logic line_o,
  output logic hi_done_o,
  output logic done_o
);
  localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_LAST = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_LAST = CNT_W'(T0L - 1);

  logic             active_q, active_d;
  logic             hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_last, lo_last;

  assign hi_last   = bit_i ? T1H_LAST : T0H_LAST;
  assign lo_last   = bit_i ? T1L_LAST : T0L_LAST;
  assign line_o    = active_q & hi_q;
  assign hi_done_o = active_q & hi_q & (cnt_q == hi_last);
  assign done_o    = active_q & ~hi_q & (cnt_q == lo_last);

  always_comb begin
    active_d = active_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    // start wins over done so consecutive bits abut with no idle cycle
    if (start_i) begin
      active_d = 1'b1;
      hi_d     = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (hi_done_o) begin
        hi_d  = 1'b0;
        cnt_d = '0;
      end else if (done_o) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      hi_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/neopixel_strand_ctrl_p.sv
// NeoPixel strand driver: double-buffered frame store serialised onto one wire.
// Ports: clock/reset; host (colour loads, send_it, auto_refresh, ready/busy/error);
// neo_data (strand pin). Loads always land in the working buffer; frames read the shadow.
module neopixel_strand_ctrl_p
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS   = 5,
  parameter int CHANNELS     = 3,
  parameter int T1H          = 35,
  parameter int T1L          = 30,
  parameter int T0H          = 18,
  parameter int T0L          = 40,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic                     clock,
  input  logic                     reset,
  neopixel_strand_ctrl_p_if.slave  host,
  output logic                     neo_data
);
  localparam int NBYTES = NUM_PIXELS * CHANNELS;
  localparam int NB     = NBYTES * 8;
  localparam int PTR_W  = $clog2(NB + 1);
  localparam int IDX_W  = $clog2(NB);
  localparam int CNT_W  = $clog2(imax(imax(imax(T1H, T1L), imax(T0H, T0L)), LATCH_CYCLES) + 1);

  localparam logic [PTR_W-1:0] LAST_BIT   = PTR_W'(NB - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [NB-1:0]    work_q, work_d;
  logic [NB-1:0]    shadow_q, shadow_d;
  logic             load_error_q, load_error_d;

  logic             load_ok;
  int               wr_byte;
  logic [IDX_W-1:0] bit_idx;
  logic             enc_start, enc_bit, enc_hi_done, enc_done, enc_line;

  // Byte j of a buffer is wire byte j (pixel*CHANNELS + slot); wire bit p is
  // bit 7-(p%8) of byte p/8, i.e. the low three pointer bits inverted.
  assign bit_idx = {ptr_q[IDX_W-1:3], ~ptr_q[2:0]};
  assign enc_bit = shadow_q[bit_idx];

  assign host.ready_to_load = 1'b1;
  assign host.ready_to_send = (state_q == ST_IDLE);
  assign host.busy          = (state_q != ST_IDLE);
  assign host.load_error    = load_error_q;
  assign neo_data           = enc_line;

  always_comb begin
    load_ok = (int'(host.pixel_index) < NUM_PIXELS) &&
              !((host.color_index == COLOR_WHITE) && (CHANNELS == 3));
    wr_byte = int'(host.pixel_index) * CHANNELS + int'(color_to_wire(host.color_index));
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lcnt_d       = lcnt_q;
    work_d       = work_q;
    shadow_d     = shadow_q;
    load_error_d = 1'b0;
    enc_start    = 1'b0;

    if (host.load_color) begin
      if (load_ok) begin
        for (int j = 0; j < NBYTES; j++) begin
          if (wr_byte == j) work_d[j*8 +: 8] = host.color_level;
        end
      end else begin
        load_error_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (host.send_it) begin
          // work_q is the pre-edge value, so a same-cycle load waits for the next frame
          shadow_d  = work_q;
          ptr_d     = '0;
          enc_start = 1'b1;
          state_d   = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (enc_hi_done) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (enc_done) begin
          if (ptr_q == LAST_BIT) begin
            lcnt_d  = '0;
            state_d = ST_LATCH;
          end else begin
            ptr_d     = ptr_q + PTR_W'(1);
            enc_start = 1'b1;
            state_d   = ST_SEND_HI;
          end
        end
      end
      ST_LATCH: begin
        if (lcnt_q == LATCH_LAST) begin
          lcnt_d = '0;
          if (host.auto_refresh) begin
            shadow_d  = work_q;
            ptr_d     = '0;
            enc_start = 1'b1;
            state_d   = ST_SEND_HI;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lcnt_d = lcnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      lcnt_q       <= '0;
      work_q       <= '0;
      shadow_q     <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lcnt_q       <= lcnt_d;
      work_q       <= work_d;
      shadow_q     <= shadow_d;
      load_error_q <= load_error_d;
    end
  end

  neopixel_bit_encoder #(
    .T1H   (T1H),
    .T1L   (T1L),
    .T0H   (T0H),
    .T0L   (T0L),
    .CNT_W (CNT_W)
  ) u_enc (
    .clock     (clock),
    .reset     (reset),
    .start_i   (enc_start),
    .bit_i     (enc_bit),
    .line_o    (enc_line),
    .hi_done_o (enc_hi_done),
    .done_o    (enc_done)
  );
endmodule

// File: tb/tb_neopixel_strand_ctrl_p.sv
module tb_neopixel_strand_ctrl_p;
  import neopixel_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  neopixel_strand_ctrl_p_if #(.PIX_W(1)) h3 ();
  neopixel_strand_ctrl_p_if #(.PIX_W(2)) h4 ();
  logic neo3, neo4;

  neopixel_strand_ctrl_p #(
    .NUM_PIXELS(2), .CHANNELS(3), .T1H(3), .T1L(4), .T0H(2), .T0L(5), .LATCH_CYCLES(10)
  ) dut3 (.clock(clock), .reset(reset), .host(h3), .neo_data(neo3));

  neopixel_strand_ctrl_p #(
    .NUM_PIXELS(3), .CHANNELS(4), .T1H(3), .T1L(4), .T0H(2), .T0L(5), .LATCH_CYCLES(10)
  ) dut4 (.clock(clock), .reset(reset), .host(h4), .neo_data(neo4));

  int   sel = 0;
  logic line_s, busy_s, lerr_s, rts_s, rtl_s;
  assign line_s = (sel == 1) ? neo4 : neo3;
  assign busy_s = (sel == 1) ? h4.busy : h3.busy;
  assign lerr_s = (sel == 1) ? h4.load_error : h3.load_error;
  assign rts_s  = (sel == 1) ? h4.ready_to_send : h3.ready_to_send;
  assign rtl_s  = (sel == 1) ? h4.ready_to_load : h3.ready_to_load;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   exp_b [16];
  logic [127:0] got;
  int           terr;
  int           guard;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] exp_frame(input int nb);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v[i] = exp_b[i/8][7-(i%8)];
    return v;
  endfunction

  task automatic drive(input bit ld, input bit snd, input int px, input int ci, input logic [7:0] lvl);
    if (sel == 1) begin
      h4.load_color = ld; h4.send_it = snd; h4.pixel_index = px[1:0];
      h4.color_index = ci[1:0]; h4.color_level = lvl;
    end else begin
      h3.load_color = ld; h3.send_it = snd; h3.pixel_index = px[0];
      h3.color_index = ci[1:0]; h3.color_level = lvl;
    end
  endtask

  task automatic do_load(input int px, input int ci, input logic [7:0] lvl);
    drive(1'b1, 1'b0, px, ci, lvl);
    @(negedge clock);
    drive(1'b0, 1'b0, 0, 0, 8'h00);
  endtask

  task automatic do_send();
    drive(1'b0, 1'b1, 0, 0, 8'h00);
    @(negedge clock);
    drive(1'b0, 1'b0, 0, 0, 8'h00);
  endtask

  // Decodes one frame from the wire: bit value from the high width, and every
  // low width checked (last bit's low includes the 10-cycle latch gap).
  task automatic recv_frame(input int nb, output logic [127:0] bits, output int errs);
    int h, l, g, lo_exp;
    bits = '0;
    errs = 0;
    g    = 0;
    while (line_s !== 1'b1 && g < 50) begin @(negedge clock); g++; end
    if (g >= 50) begin
      errs = 999;
      return;
    end
    for (int i = 0; i < nb; i++) begin
      h = 0;
      while (line_s === 1'b1 && h < 20) begin h++; @(negedge clock); end
      l = 0;
      while (line_s === 1'b0 && busy_s === 1'b1 && l < 40) begin l++; @(negedge clock); end
      bits[i] = (h == 3);
      lo_exp  = ((h == 3) ? 4 : 5) + ((i == nb - 1) ? 10 : 0);
      if ((h != 2 && h != 3) || l != lo_exp) errs++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_b[i] = 8'h00;
    reset = 1'b1;
    h3.auto_refresh = 1'b0;
    h4.auto_refresh = 1'b0;
    sel = 1; drive(1'b0, 1'b0, 0, 0, 8'h00);
    sel = 0; drive(1'b0, 1'b0, 0, 0, 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_neo", line_s, 1'b0);
    check("rst_busy", busy_s, 1'b0);
    check("rst_lerr", lerr_s, 1'b0);
    check("rst_rts", rts_s, 1'b1);
    check("rst_rtl", rtl_s, 1'b1);

    // Single 1-bit at the start of a 48-bit frame
    do_load(0, COLOR_GREEN, 8'h80);
    exp_b[0] = 8'h80;
    check("load_ok_noerr", lerr_s, 1'b0);
    do_send();
    recv_frame(48, got, terr);
    check("f1_timing", terr, 0);
    check("f1_bits", got, exp_frame(48));
    check("f1_rts_after", rts_s, 1'b1);
    check("f1_busy_after", busy_s, 1'b0);

    // Load pixel1 blue during SEND_LO of bit 5: current frame unaffected
    do_send();
    fork
      begin
        recv_frame(48, got, terr);
      end
      begin
        repeat (38) @(negedge clock);
        check("mid_rtl", rtl_s, 1'b1);
        check("mid_rts", rts_s, 1'b0);
        drive(1'b1, 1'b0, 1, COLOR_BLUE, 8'hFF);
        @(negedge clock);
        drive(1'b0, 1'b0, 0, 0, 8'h00);
      end
    join
    check("f2_timing", terr, 0);
    check("f2_bits_old", got, exp_frame(48));
    exp_b[5] = 8'hFF;
    do_send();
    recv_frame(48, got, terr);
    check("f3_timing", terr, 0);
    check("f3_bits_new", got, exp_frame(48));

    // White on a 3-channel strand is rejected
    do_load(0, COLOR_WHITE, 8'h77);
    check("white3_lerr", lerr_s, 1'b1);
    @(negedge clock);
    check("white3_lerr_pulse", lerr_s, 1'b0);

    // Load and send in the same IDLE cycle
    drive(1'b1, 1'b1, 0, COLOR_RED, 8'h55);
    @(negedge clock);
    drive(1'b0, 1'b0, 0, 0, 8'h00);
    check("same_busy", busy_s, 1'b1);
    recv_frame(48, got, terr);
    check("f4_timing", terr, 0);
    check("f4_bits_old", got, exp_frame(48));
    exp_b[1] = 8'h55;
    do_send();
    recv_frame(48, got, terr);
    check("f5_timing", terr, 0);
    check("f5_bits_new", got, exp_frame(48));

    // Auto refresh: back-to-back frames, send_it while busy ignored
    h3.auto_refresh = 1'b1;
    do_send();
    recv_frame(48, got, terr);
    check("auto1_timing", terr, 0);
    check("auto1_bits", got, exp_frame(48));
    fork
      begin
        recv_frame(48, got, terr);
      end
      begin
        h3.send_it = 1'b1;
        h3.auto_refresh = 1'b0;
        check("auto_rts_busy", rts_s, 1'b0);
        @(negedge clock);
        h3.send_it = 1'b0;
      end
    join
    check("auto2_timing", terr, 0);
    check("auto2_bits", got, exp_frame(48));
    repeat (3) @(negedge clock);
    check("auto_not_queued", busy_s, 1'b0);

    // Asynchronous reset in the middle of a frame
    do_send();
    repeat (66) @(negedge clock);
    guard = 0;
    while (line_s !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    check("pre_reset_line", line_s, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_neo", line_s, 1'b0);
    check("async_rst_busy", busy_s, 1'b0);
    check("async_rst_rts", rts_s, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 16; i++) exp_b[i] = 8'h00;
    do_send();
    recv_frame(48, got, terr);
    check("post_rst_timing", terr, 0);
    check("post_rst_bits", got, exp_frame(48));

    // 4-channel strand: W follows B, out-of-range pixel rejected
    sel = 1;
    do_load(0, COLOR_GREEN, 8'h01);
    do_load(0, COLOR_WHITE, 8'hA5);
    do_load(2, COLOR_BLUE, 8'h80);
    do_load(3, COLOR_RED, 8'h33);
    check("pix_range_lerr", lerr_s, 1'b1);
    exp_b[0]  = 8'h01;
    exp_b[3]  = 8'hA5;
    exp_b[10] = 8'h80;
    do_send();
    recv_frame(96, got, terr);
    check("grbw_timing", terr, 0);
    check("grbw_bits", got, exp_frame(96));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
